mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the processor's single-port synchronous memory between the instruction-fetch path and the load/store data path. Each side issues a request/grant/valid transaction and the arbiter sequences exactly one memory access at a time through a fixed-latency access window. Data accesses normally have priority, and a fairness rule prevents fetch starvation. The block sits between `processor`'s fetch/execute logic and the memory macro.

## Interface
- `DATA_W`, 8, memory word width
- `ADDR_W`, 8, memory address width
- `MEM_LATENCY`, 1, cycles from `mem_en_out` high to `mem_rdata_in` valid; legal values 1..15
- `clk_in`  in  1  single clock; all logic on rising edge
- `rst_in`  in  1  synchronous, active-low reset
- `if_req_in`  in  1  fetch request
- `if_addr_in`  in  ADDR_W  fetch address
- `if_gnt_out`  out  1  one-cycle pulse: fetch request accepted
- `if_valid_out`  out  1  one-cycle pulse: `if_rdata_out` valid
- `if_rdata_out`  out  DATA_W  fetched word; holds until next fetch completion
- `d_req_in`  in  1  data request
- `d_we_in`  in  1  1 = write, 0 = read
- `d_addr_in`  in  ADDR_W  data address
- `d_wdata_in`  in  DATA_W  write data
- `d_gnt_out`  out  1  one-cycle pulse: data request accepted
- `d_valid_out`  out  1  one-cycle pulse: data access complete, for reads and writes
- `d_rdata_out`  out  DATA_W  read word; updated only on read completion
- `mem_en_out`  out  1  memory enable; one-cycle pulse per access
- `mem_we_out`  out  1  memory write strobe; high only together with `mem_en_out`
- `mem_addr_out`  out  ADDR_W  latched address
- `mem_wdata_out`  out  DATA_W  latched write data
- `mem_rdata_in`  in  DATA_W  memory read data
- `busy_out`  out  1  high whenever state is not IDLE

## Operation
- States:
  - IDLE
  - ACCESS: latency counter running
  - RESP: completion cycle
- Arbitration runs at the clock edge ending IDLE or RESP. It samples `if_req_in` and `d_req_in`. Requests are ignored in ACCESS.
- Winner selection:
  - Only one side requesting: that side wins.
  - Both requesting: data wins, unless the last grant was data, in which case fetch wins. Sustained contention therefore alternates D, F, D, F.
  - `last_owner` register resets to fetch.
- On a win, the arbiter does all of the following at the same edge:
  - Latches the winner's address, `we` (fetch forces 0) and wdata into the `mem_*` outputs.
  - Records the owner.
  - Loads the counter with MEM_LATENCY.
  - Enters ACCESS.
- First ACCESS cycle:
  - Winner's `gnt_out` = 1 and `mem_en_out` = 1.
  - `mem_we_out` = 1 if the access is a write.
  - All three drop to 0 in the following cycles.
- ACCESS decrements the counter each cycle. When the count reaches 0, the arbiter captures `mem_rdata_in` and enters RESP.
- RESP, owner's side:
  - `valid_out` = 1.
  - `rdata_out` = captured word; for a data write, `d_rdata_out` keeps its old value.
- RESP then arbitrates as IDLE does: to ACCESS if any request is present, else to IDLE.
- `mem_addr_out`, `mem_wdata_out` and `mem_we` intent hold stable from grant through RESP.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Deassert req in the cycle after gnt unless a new access is wanted.
  - Any req sampled in IDLE/RESP is treated as a new request.
- Reset (`rst_in` = 0 at any edge), including mid-ACCESS or mid-RESP:
  - State goes to IDLE and the in-flight access is abandoned with no valid pulse.
  - `last_owner` = fetch.
  - All outputs = 0, including both rdata registers and all `mem_*` outputs.

## Timing
- Request sampled at edge E0. Gnt and `mem_en_out` are high in cycle 1, `mem_rdata_in` is sampled at the end of cycle MEM_LATENCY, and valid is high in cycle MEM_LATENCY+1.
- With MEM_LATENCY = 1: gnt in cycle 1, valid in cycle 2.
- Back-to-back throughput: one access per MEM_LATENCY+1 cycles. The next gnt is in the cycle after RESP, with no idle cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_in` = 0 for 2 cycles with both reqs high -> all outputs 0, `busy_out` 0, no gnt.
- Single fetch, MEM_LATENCY = 1: `if_addr_in` = 0x10, memory returns 0xA5 -> `if_gnt_out` and `mem_en_out` in cycle 1 with `mem_addr_out` = 0x10 and `mem_we_out` = 0; `if_valid_out` in cycle 2 with `if_rdata_out` = 0xA5; `d_*` outputs stay 0.
- Data write: `d_we_in` = 1, addr 0x20, wdata 0x3C -> `mem_en_out` = `mem_we_out` = 1 for exactly one cycle with addr 0x20 and wdata 0x3C; `d_valid_out` pulses; `d_rdata_out` unchanged.
- Sustained contention: both reqs held high for 8 accesses -> grant order D, F, D, F, D, F, D, F; each gnt is one cycle; no cycle has both gnts high.
- Latency parameter: MEM_LATENCY = 3, data read of 0x05 returning 0x77 -> gnt in cycle 1, valid in cycle 4 with `d_rdata_out` = 0x77, `busy_out` high in cycles 1-4.
- Reset mid-access: assert `rst_in` = 0 in the second ACCESS cycle (MEM_LATENCY = 3) -> IDLE next cycle, no valid pulse; first contended grant after release goes to data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch path and the load/store data path. One access is in
// flight at a time through a fixed MEM_LATENCY window (legal 1..15).
// Data normally wins contention; after a data grant, a contending fetch wins.
// Every output is registered; inputs only steer the next-state decision.
module mem_arbiter #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic              if_gnt_out,
   output logic              if_valid_out,
   output logic [DATA_W-1:0] if_rdata_out,
   input  logic              d_req_in,
   input  logic              d_we_in,
   input  logic [ADDR_W-1:0] d_addr_in,
   input  logic [DATA_W-1:0] d_wdata_in,
   output logic              d_gnt_out,
   output logic              d_valid_out,
   output logic [DATA_W-1:0] d_rdata_out,
   output logic              mem_en_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   input  logic [DATA_W-1:0] mem_rdata_in,
   output logic              busy_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t     state;
   logic [3:0] cnt;      // cycles left in the access window
   logic       last_d;   // last grant went to the data side
   logic       owner_d;  // current access belongs to the data side
   logic       cur_we;   // current access is a write
   logic       win_d;
   logic       win_f;

   // Winner for an arbitration edge: data first, fetch after a data grant.
   always_comb begin
      // NOTE: defaults first so every path assigns both signals and no latch is inferred.
      win_d = 1'b0;
      win_f = 1'b0;
      if (d_req_in && !(if_req_in && last_d)) begin
         win_d = 1'b1;
      end else if (if_req_in) begin
         win_f = 1'b1;
      end
   end

   // Access sequencer: arbitrate in IDLE/RESP, count the window in ACCESS.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
         state         <= IDLE;
         cnt           <= 4'd0;
         last_d        <= 1'b0;
         owner_d       <= 1'b0;
         cur_we        <= 1'b0;
         if_gnt_out    <= 1'b0;
         if_valid_out  <= 1'b0;
         if_rdata_out  <= '0;
         d_gnt_out     <= 1'b0;
         d_valid_out   <= 1'b0;
         d_rdata_out   <= '0;
         mem_en_out    <= 1'b0;
         mem_we_out    <= 1'b0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         busy_out      <= 1'b0;
      end else begin
         // Pulse outputs fall back to 0 unless re-asserted below.
         if_gnt_out   <= 1'b0;
         d_gnt_out    <= 1'b0;
         mem_en_out   <= 1'b0;
         mem_we_out   <= 1'b0;
         if_valid_out <= 1'b0;
         d_valid_out  <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (win_d || win_f) begin
                  state         <= ACCESS;
                  busy_out      <= 1'b1;
                  cnt           <= 4'(MEM_LATENCY);
                  owner_d       <= win_d;
                  last_d        <= win_d;
                  cur_we        <= win_d && d_we_in;
                  if_gnt_out    <= win_f;
                  d_gnt_out     <= win_d;
                  mem_en_out    <= 1'b1;
                  mem_we_out    <= win_d && d_we_in;
                  mem_addr_out  <= win_d ? d_addr_in : if_addr_in;
                  // Fetches carry no write data; drive zeros rather than stale data.
                  mem_wdata_out <= win_d ? d_wdata_in : '0;
               end else begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end
            ACCESS: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
                  if (owner_d) begin
                     d_valid_out <= 1'b1;
                     if (!cur_we) begin
                        d_rdata_out <= mem_rdata_in;
                     end
                  end else begin
                     if_valid_out <= 1'b1;
                     if_rdata_out <= mem_rdata_in;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (MEM_LATENCY 1 and 3) each driven by
// directed and random traffic. A transaction-level model predicts every
// output per cycle; a memory environment returns read data only in the
// cycle it is due and junk otherwise.
module tb_mem_arbiter;

   logic clk;
   int   checks;
   int   errors;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : u
      localparam int L = (gi == 0) ? 1 : 3;

      logic       rst;
      logic       if_req, if_gnt, if_valid;
      logic [7:0] if_addr, if_rdata;
      logic       d_req, d_we, d_gnt, d_valid;
      logic [7:0] d_addr, d_wdata, d_rdata;
      logic       mem_en, mem_we, busy;
      logic [7:0] mem_addr, mem_wdata, mem_rdata;
      bit         fin;

      mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LATENCY(L)) dut (
         .clk_in       (clk),
         .rst_in       (rst),
         .if_req_in    (if_req),
         .if_addr_in   (if_addr),
         .if_gnt_out   (if_gnt),
         .if_valid_out (if_valid),
         .if_rdata_out (if_rdata),
         .d_req_in     (d_req),
         .d_we_in      (d_we),
         .d_addr_in    (d_addr),
         .d_wdata_in   (d_wdata),
         .d_gnt_out    (d_gnt),
         .d_valid_out  (d_valid),
         .d_rdata_out  (d_rdata),
         .mem_en_out   (mem_en),
         .mem_we_out   (mem_we),
         .mem_addr_out (mem_addr),
         .mem_wdata_out(mem_wdata),
         .mem_rdata_in (mem_rdata),
         .busy_out     (busy)
      );

      // Memory seen by the DUT, and the model's own copy of what it should hold.
      logic [7:0] env_mem [256];
      logic [7:0] ref_mem [256];
      int         k;

      // Memory environment: data is correct only in cycle L of an access.
      initial begin
         k = 0;
         mem_rdata = 8'h00;
         forever begin
            @(negedge clk);
            if (mem_en) k = 1;
            else if (k != 0 && k < 1000) k++;
            if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
            mem_rdata = (k == L) ? env_mem[mem_addr] : 8'($urandom);
         end
      end

      // Transaction-level model: one record per granted access.
      int         cyc;
      bit         act, o_d, o_we, last_d, wd;
      logic [7:0] o_addr, o_wdata;
      int         g_c, v_c;
      logic [7:0] e_ifr, e_dr, e_ma, e_mw;

      initial begin
         cyc = 0;
         act = 0;
         last_d = 0;
         forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
               act = 0; last_d = 0;
               e_ifr = 0; e_dr = 0; e_ma = 0; e_mw = 0;
            end else begin
               if (act && cyc == v_c) begin
                  if (!o_d) e_ifr = ref_mem[o_addr];
                  else if (!o_we) e_dr = ref_mem[o_addr];
               end
               if (!act || cyc - 1 >= v_c) begin
                  act = 0;
                  if (if_req || d_req) begin
                     wd      = d_req && !(if_req && last_d);
                     act     = 1;
                     o_d     = wd;
                     o_we    = wd && d_we;
                     o_addr  = wd ? d_addr : if_addr;
                     o_wdata = wd ? d_wdata : 8'h00;
                     g_c     = cyc;
                     v_c     = cyc + L;
                     last_d  = wd;
                     e_ma    = o_addr;
                     e_mw    = o_wdata;
                     if (o_we) ref_mem[o_addr] = o_wdata;
                  end
               end
            end
         end
      end

      // Compare every DUT output against the model once per cycle.
      initial begin
         bit in_t, first;
         forever begin
            @(negedge clk);
            if (cyc > 0) begin
               in_t  = act && cyc >= g_c && cyc <= v_c;
               first = act && cyc == g_c;
               check($sformatf("L%0d busy", L), 32'(busy), 32'(in_t));
               check($sformatf("L%0d if_gnt", L), 32'(if_gnt), 32'(first && !o_d));
               check($sformatf("L%0d d_gnt", L), 32'(d_gnt), 32'(first && o_d));
               check($sformatf("L%0d mem_en", L), 32'(mem_en), 32'(first));
               check($sformatf("L%0d mem_we", L), 32'(mem_we), 32'(first && o_we));
               check($sformatf("L%0d if_valid", L), 32'(if_valid), 32'(act && cyc == v_c && !o_d));
               check($sformatf("L%0d d_valid", L), 32'(d_valid), 32'(act && cyc == v_c && o_d));
               check($sformatf("L%0d if_rdata", L), 32'(if_rdata), 32'(e_ifr));
               check($sformatf("L%0d d_rdata", L), 32'(d_rdata), 32'(e_dr));
               check($sformatf("L%0d mem_addr", L), 32'(mem_addr), 32'(e_ma));
               check($sformatf("L%0d mem_wdata", L), 32'(mem_wdata), 32'(e_mw));
            end
         end
      end

      task automatic drive_point();
         @(posedge clk);
         #1;
      endtask

      // Raise one side's request and return at the negedge where its gnt shows.
      task automatic issue(input bit is_d, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdat, input string tag);
         bit seen;
         seen = 0;
         if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdat;
         end else begin
            if_req = 1; if_addr = addr;
         end
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_d ? d_gnt : if_gnt;
         end
         check($sformatf("L%0d %s gnt seen", L, tag), 32'(seen), 32'd1);
      endtask

      // Stimulus: reset, directed cases, reset mid-access, contention, random.
      initial begin
         int ngr, last_g;
         fin = 0;
         for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
         end
         env_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
         env_mem[8'h05] = 8'h77; ref_mem[8'h05] = 8'h77;

         rst = 0; if_req = 1; d_req = 1; d_we = 0;
         if_addr = 8'h01; d_addr = 8'h02; d_wdata = 8'h00;
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("L%0d reset busy", L), 32'(busy), 32'd0);
         check($sformatf("L%0d reset gnts", L), 32'({if_gnt, d_gnt, mem_en}), 32'd0);
         check($sformatf("L%0d reset d_rdata", L), 32'(d_rdata), 32'd0);
         drive_point();
         rst = 1; if_req = 0; d_req = 0;

         // Single fetch of 0x10 returning 0xA5.
         issue(0, 0, 8'h10, 8'h00, "fetch");
         check($sformatf("L%0d fetch mem_en", L), 32'(mem_en), 32'd1);
         check($sformatf("L%0d fetch mem_addr", L), 32'(mem_addr), 32'h10);
         check($sformatf("L%0d fetch mem_we", L), 32'(mem_we), 32'd0);
         drive_point();
         if_req = 0;
         repeat (L) @(negedge clk);
         check($sformatf("L%0d fetch valid", L), 32'(if_valid), 32'd1);
         check($sformatf("L%0d fetch rdata", L), 32'(if_rdata), 32'hA5);
         check($sformatf("L%0d fetch d side quiet", L), 32'({d_valid, d_rdata}), 32'd0);

         // Data write 0x3C to 0x20.
         drive_point();
         issue(1, 1, 8'h20, 8'h3C, "write");
         check($sformatf("L%0d write strobes", L), 32'({mem_en, mem_we}), 32'h3);
         check($sformatf("L%0d write addr", L), 32'(mem_addr), 32'h20);
         check($sformatf("L%0d write wdata", L), 32'(mem_wdata), 32'h3C);
         drive_point();
         d_req = 0; d_we = 0;
         @(negedge clk);
         check($sformatf("L%0d write strobes drop", L), 32'({mem_en, mem_we}), 32'h0);
         repeat (L - 1) @(negedge clk);
         check($sformatf("L%0d write valid", L), 32'(d_valid), 32'd1);
         check($sformatf("L%0d write keeps d_rdata", L), 32'(d_rdata), 32'd0);

         // Data read of 0x05 returning 0x77; busy across the whole window.
         drive_point();
         issue(1, 0, 8'h05, 8'h00, "read");
         check($sformatf("L%0d read busy c1", L), 32'(busy), 32'd1);
         drive_point();
         d_req = 0;
         for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            check($sformatf("L%0d read busy c%0d", L, i + 1), 32'(busy), 32'd1);
         end
         check($sformatf("L%0d read valid", L), 32'(d_valid), 32'd1);
         check($sformatf("L%0d read rdata", L), 32'(d_rdata), 32'h77);
         @(negedge clk);
         check($sformatf("L%0d read idle after", L), 32'(busy), 32'd0);

         // Reset in the second cycle of an access abandons it.
         drive_point();
         issue(1, 0, 8'h30, 8'h00, "abort");
         drive_point();
         d_req = 0; rst = 0;
         drive_point();
         rst = 1;
         @(negedge clk);
         check($sformatf("L%0d abort idle", L), 32'({busy, d_valid}), 32'd0);
         @(negedge clk);
         check($sformatf("L%0d abort no valid", L), 32'(d_valid), 32'd0);

         // Sustained contention: D, F, D, F... at one grant per L+1 cycles.
         drive_point();
         if_req = 1; d_req = 1; d_we = 0; d_addr = 8'h40; if_addr = 8'h41;
         ngr = 0; last_g = 0;
         for (int i = 0; i < 300 && ngr < 8; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
               check($sformatf("L%0d both gnts", L), 32'(if_gnt & d_gnt), 32'd0);
               check($sformatf("L%0d grant %0d is data", L, ngr), 32'(d_gnt), 32'((ngr % 2) == 0));
               if (ngr > 0) check($sformatf("L%0d grant spacing", L), 32'(cyc - last_g), 32'(L + 1));
               last_g = cyc;
               ngr++;
            end
         end
         check($sformatf("L%0d contention grants", L), 32'(ngr), 32'd8);
         drive_point();
         if_req = 0; d_req = 0;

         // Random traffic with occasional resets.
         for (int i = 0; i < 400; i++) begin
            drive_point();
            rst     = ($urandom_range(63) != 0);
            if_req  = 1'($urandom_range(1));
            d_req   = 1'($urandom_range(1));
            d_we    = 1'($urandom_range(1));
            if_addr = 8'($urandom_range(15));
            d_addr  = 8'($urandom_range(15));
            d_wdata = 8'($urandom);
         end
         drive_point();
         rst = 1; if_req = 0; d_req = 0;
         repeat (20) @(posedge clk);
         fin = 1;
      end
   end

   // Summary once both instances finish, with a bound on total run time.
   initial begin
      int n;
      checks = 0;
      errors = 0;
      n = 0;
      while (!(u[0].fin && u[1].fin) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      check("stimulus finished", 32'(u[0].fin && u[1].fin), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
